// File: rtl/pool_upsample_unit.sv
// pool_upsample_unit: streaming bypass / 2x2 maxpool (stride 1, 2) / 2x nearest upsample over one shared line buffer.
// Build with PP_RELU_EN defined to force negative output lanes to zero.
module pool_upsample_unit #(
   parameter int LANES = 16,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_ROW_BEATS = 32,
   parameter int MAX_ROWS = 512,
   localparam int W = LANES*DATA_WIDTH,
   localparam int RBW = $clog2(MAX_ROW_BEATS+1),
   localparam int RW = $clog2(MAX_ROWS+1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:0]     mode,
   input  logic [RBW-1:0] row_beats,
   input  logic [RW-1:0]  num_rows,
   output logic           busy,
   output logic           done,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out_data,
   output logic           out_last
);
   typedef enum logic [2:0] {IDLE, RUN, EXPAND, REPLAY, FLUSH, DONE} state_t;
   localparam int DW = DATA_WIDTH;
   localparam int H = LANES/2;
   localparam int PW = MAX_ROW_BEATS > 1 ? $clog2(MAX_ROW_BEATS) : 1;

   state_t state, nx_state;
   logic [1:0] mode_q, nx_mode;
   logic [RBW-1:0] rb_q, nx_rb, bcnt, nx_bcnt;
   logic [RW-1:0] nr_q, nx_nr, rcnt, nx_rcnt;
   logic phase, nx_phase, nx_valid, nx_last, last_c, emit, push, pop, clr;
   logic adv, acc, lb, lr, m2odd, fin_hs;
   logic [W-1:0] hold, nx_hold, nx_data, res, rd_data;
   logic [W-1:0] mem [MAX_ROW_BEATS];
   logic [PW-1:0] wr_ptr, rd_ptr;

   function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < LANES; i++)
         vmax[i*DW +: DW] = $signed(a[i*DW +: DW]) > $signed(b[i*DW +: DW]) ? a[i*DW +: DW] : b[i*DW +: DW];
   endfunction

   function automatic logic [W-1:0] hmax(input logic [W-1:0] v);
      hmax = v;
      for (int i = 0; i < LANES-1; i++)
         hmax[i*DW +: DW] = $signed(v[i*DW +: DW]) > $signed(v[(i+1)*DW +: DW]) ? v[i*DW +: DW] : v[(i+1)*DW +: DW];
   endfunction

   function automatic logic [W-1:0] halve(input logic [W-1:0] v);
      halve = '0;
      for (int j = 0; j < H; j++) halve[j*DW +: DW] = v[2*j*DW +: DW];
   endfunction

   function automatic logic [W-1:0] widen(input logic [W-1:0] v, input logic hi);
      for (int i = 0; i < LANES; i++) widen[i*DW +: DW] = v[((hi ? H : 0) + i/2)*DW +: DW];
   endfunction

   function automatic logic [W-1:0] relu(input logic [W-1:0] v);
`ifdef PP_RELU_EN
      relu = v;
      for (int i = 0; i < LANES; i++) if (v[i*DW+DW-1]) relu[i*DW +: DW] = '0;
`else
      relu = v;
`endif
   endfunction

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      inc = p == PW'(MAX_ROW_BEATS-1) ? '0 : p + PW'(1);
   endfunction

   assign adv = !out_valid || out_ready;
   assign in_ready = (state == RUN) && adv;
   assign acc = in_valid && in_ready;
   assign lb = bcnt == rb_q - RBW'(1);
   assign lr = rcnt == nr_q - RW'(1);
   // Stride-2 frames with an odd row count end on the discarded row, not on the last output handshake.
   assign m2odd = (mode_q == 2'd2) && nr_q[0];
   assign fin_hs = out_valid && out_ready && out_last;
   assign rd_data = mem[rd_ptr];
   assign busy = state != IDLE;
   assign done = state == DONE;

   always_comb begin
      nx_state = state;
      nx_mode = mode_q;
      nx_rb = rb_q;
      nx_nr = nr_q;
      nx_bcnt = bcnt;
      nx_rcnt = rcnt;
      nx_phase = phase;
      nx_hold = hold;
      nx_valid = out_valid && !out_ready;
      nx_data = out_data;
      nx_last = out_last;
      res = '0;
      last_c = 1'b0;
      emit = 1'b0;
      push = 1'b0;
      pop = 1'b0;
      clr = 1'b0;
      case (state)
         IDLE: if (start) begin
            nx_mode = mode;
            nx_rb = row_beats > RBW'(MAX_ROW_BEATS) ? RBW'(MAX_ROW_BEATS) : row_beats;
            nx_nr = num_rows;
            nx_bcnt = '0;
            nx_rcnt = '0;
            nx_phase = 1'b0;
            clr = 1'b1;
            nx_state = (row_beats == '0 || num_rows == '0) ? DONE : RUN;
         end
         RUN: begin
            if (fin_hs && !m2odd) nx_state = DONE;
            else if (acc) begin
               nx_bcnt = lb ? '0 : bcnt + RBW'(1);
               nx_rcnt = lb ? rcnt + RW'(1) : rcnt;
               case (mode_q)
                  2'd0: begin
                     emit = 1'b1;
                     res = in_data;
                     last_c = lb && lr;
                  end
                  2'd1: begin
                     push = 1'b1;
                     pop = rcnt != '0;
                     emit = pop;
                     res = hmax(vmax(rd_data, in_data));
                     if (lb && lr) nx_state = FLUSH;
                  end
                  2'd2: begin
                     push = !rcnt[0];
                     pop = rcnt[0];
                     emit = pop;
                     res = halve(hmax(vmax(rd_data, in_data)));
                     last_c = lb && (lr || rcnt == nr_q - RW'(2));
                     if (lb && lr && m2odd) nx_state = DONE;
                  end
                  default: begin
                     push = 1'b1;
                     emit = 1'b1;
                     res = widen(in_data, 1'b0);
                     nx_hold = in_data;
                     nx_bcnt = bcnt;
                     nx_rcnt = rcnt;
                     nx_state = EXPAND;
                  end
               endcase
            end
         end
         EXPAND: if (adv) begin
            emit = 1'b1;
            res = widen(hold, 1'b1);
            nx_bcnt = lb ? '0 : bcnt + RBW'(1);
            nx_state = lb ? REPLAY : RUN;
         end
         REPLAY: begin
            if (fin_hs) nx_state = DONE;
            else if (adv) begin
               emit = 1'b1;
               pop = !phase;
               res = widen(phase ? hold : rd_data, phase);
               nx_hold = phase ? hold : rd_data;
               nx_phase = !phase;
               last_c = phase && lb && lr;
               if (phase) nx_bcnt = lb ? '0 : bcnt + RBW'(1);
               if (phase && lb && !lr) begin
                  nx_rcnt = rcnt + RW'(1);
                  nx_state = RUN;
               end
            end
         end
         FLUSH: begin
            if (fin_hs) nx_state = DONE;
            else if (adv) begin
               pop = 1'b1;
               emit = 1'b1;
               res = hmax(rd_data);
               last_c = lb;
               nx_bcnt = lb ? '0 : bcnt + RBW'(1);
            end
         end
         default: nx_state = IDLE;
      endcase
      if (emit) begin
         nx_valid = 1'b1;
         nx_data = relu(res);
         nx_last = last_c;
      end
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         mode_q <= '0;
         rb_q <= '0;
         nr_q <= '0;
         bcnt <= '0;
         rcnt <= '0;
         phase <= 1'b0;
         hold <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         state <= nx_state;
         mode_q <= nx_mode;
         rb_q <= nx_rb;
         nr_q <= nx_nr;
         bcnt <= nx_bcnt;
         rcnt <= nx_rcnt;
         phase <= nx_phase;
         hold <= nx_hold;
         out_valid <= nx_valid;
         out_data <= nx_data;
         out_last <= nx_last;
         wr_ptr <= clr ? '0 : push ? inc(wr_ptr) : wr_ptr;
         rd_ptr <= clr ? '0 : pop ? inc(rd_ptr) : rd_ptr;
      end

   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_pool_upsample_unit.sv
// tb_pool_upsample_unit: randomized frames against a frame-level reference model with a queued scoreboard.
module tb_pool_upsample_unit;
   localparam int L = 4, DW = 16, W = L*DW, MRB = 8, MR = 16;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [1:0] mode = '0;
   logic [3:0] row_beats = '0;
   logic [4:0] num_rows = '0;
   logic [W-1:0] in_data = '0;
   logic busy, done, in_ready, out_valid, out_last;
   logic [W-1:0] out_data;

   typedef struct {logic [W-1:0] d; logic l;} exp_t;
   exp_t exp_q[$];
   logic [W-1:0] img [MR][MRB];
   int checks = 0, errors = 0, done_cnt = 0, rdy_pct = 100;
   bit mon_en = 1'b1, lat_chk = 1'b0, done_due = 1'b0, m2odd = 1'b0;

   pool_upsample_unit #(.LANES(L), .DATA_WIDTH(DW), .MAX_ROW_BEATS(MRB), .MAX_ROWS(MR)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .row_beats(row_beats), .num_rows(num_rows),
      .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string nm, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int px(input logic [W-1:0] v, input int i);
      return int'($signed(v[i*DW +: DW]));
   endfunction

   function automatic logic [W-1:0] set_px(input logic [W-1:0] v, input int i, input int x);
      v[i*DW +: DW] = DW'(x);
      return v;
   endfunction

   function automatic logic [W-1:0] mk(input int a, input int b, input int c, input int d);
      return set_px(set_px(set_px(set_px('0, 0, a), 1, b), 2, c), 3, d);
   endfunction

   function automatic logic [W-1:0] mx(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] r = '0;
      for (int i = 0; i < L; i++) r = set_px(r, i, px(a, i) > px(b, i) ? px(a, i) : px(b, i));
      return r;
   endfunction

   function automatic logic [W-1:0] hm(input logic [W-1:0] v);
      logic [W-1:0] r = v;
      for (int i = 0; i < L-1; i++) r = set_px(r, i, px(v, i) > px(v, i+1) ? px(v, i) : px(v, i+1));
      return r;
   endfunction

   function automatic logic [W-1:0] cmp(input logic [W-1:0] v);
      logic [W-1:0] r = '0;
      for (int j = 0; j < L/2; j++) r = set_px(r, j, px(v, 2*j));
      return r;
   endfunction

   function automatic logic [W-1:0] up(input logic [W-1:0] v, input int hi);
      logic [W-1:0] r = '0;
      for (int i = 0; i < L; i++) r = set_px(r, i, px(v, hi*L/2 + i/2));
      return r;
   endfunction

   function automatic logic [W-1:0] fix(input logic [W-1:0] v);
`ifdef PP_RELU_EN
      for (int i = 0; i < L; i++) if (px(v, i) < 0) v = set_px(v, i, 0);
`endif
      return v;
   endfunction

   task automatic expect_beat(input logic [W-1:0] v);
      exp_q.push_back('{fix(v), 1'b0});
   endtask

   task automatic model(input int m, input int rb, input int nr);
      int n0 = exp_q.size();
      if (rb > 0 && nr > 0)
         case (m)
            0: for (int r = 0; r < nr; r++) for (int b = 0; b < rb; b++) expect_beat(img[r][b]);
            1: begin
               for (int r = 1; r < nr; r++) for (int b = 0; b < rb; b++) expect_beat(hm(mx(img[r-1][b], img[r][b])));
               for (int b = 0; b < rb; b++) expect_beat(hm(img[nr-1][b]));
            end
            2: for (int r = 1; r < nr; r += 2) for (int b = 0; b < rb; b++) expect_beat(cmp(hm(mx(img[r-1][b], img[r][b]))));
            default: for (int r = 0; r < nr; r++) for (int k = 0; k < 2; k++) for (int b = 0; b < rb; b++) begin
               expect_beat(up(img[r][b], 0));
               expect_beat(up(img[r][b], 1));
            end
         endcase
      if (exp_q.size() > n0) exp_q[exp_q.size()-1].l = 1'b1;
   endtask

   task automatic fill;
      for (int r = 0; r < MR; r++) for (int b = 0; b < MRB; b++) for (int i = 0; i < L; i++)
         img[r][b] = set_px(img[r][b], i, int'($urandom_range(40)) - 20);
   endtask

   task automatic do_reset;
      int base;
      in_valid = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk(out_data == '0, "reset_data", out_data, 0);
      chk({busy, done, in_ready, out_valid, out_last} == 5'd0, "reset_ctrl", {busy, done, in_ready, out_valid, out_last}, 0);
      exp_q.delete();
      base = done_cnt;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk(done_cnt == base, "no_done_after_reset", done_cnt - base, 0);
      mon_en = 1'b1;
   endtask

   task automatic run_frame(input int m, input int rb, input int nr, input int abort);
      int base, t;
      bit acc;
      base = done_cnt;
      model(m, rb, nr);
      m2odd = (m == 2) && (nr % 2 == 1);
      lat_chk = (rdy_pct == 100) && (m == 0 || m == 3);
      mode = 2'(m);
      row_beats = 4'(rb);
      num_rows = 5'(nr);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      chk(busy, "busy_after_start", busy, 1);
      @(posedge clk);
      #1;
      for (int r = 0; r < nr; r++) for (int b = 0; b < rb; b++) begin
         if (abort >= 0 && r*rb + b == abort) begin
            do_reset();
            return;
         end
         in_data = img[r][b];
         in_valid = 1'b1;
         t = 0;
         do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
         end while (!acc && t < 500);
         in_valid = 1'b0;
         if (!acc) chk(1'b0, "input_timeout", 0, 1);
         if (lat_chk) begin
            @(negedge clk);
            chk(out_valid, "out_latency", out_valid, 1);
            if (m == 3) chk(!in_ready, "expand_ready_low", in_ready, 0);
            @(posedge clk);
            #1;
         end else if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      t = 0;
      while (done_cnt == base && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk(done_cnt == base + 1, "done_pulse", done_cnt - base, 1);
      repeat (3) @(posedge clk);
      #1;
      chk(exp_q.size() == 0, "all_beats_out", exp_q.size(), 0);
      chk(done_cnt == base + 1, "single_done", done_cnt - base, 1);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      out_ready = $urandom_range(99) < rdy_pct;
   end

   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (done_due) chk(done, "done_after_last", done, 1);
      done_due = 1'b0;
      if (mon_en && out_valid) begin
         if (exp_q.size() == 0) chk(1'b0, "unexpected_beat", {out_last, out_data}, 0);
         else begin
            chk(out_data == exp_q[0].d && out_last == exp_q[0].l, "out_beat", {out_last, out_data}, {exp_q[0].l, exp_q[0].d});
            if (out_ready) begin
               done_due = out_last && !m2odd;
               void'(exp_q.pop_front());
            end
         end
      end
      if (mon_en && in_ready && out_valid && !out_ready) chk(1'b0, "in_ready_while_stalled", 1, 0);
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(out_data == '0, "reset_data", out_data, 0);
      chk({busy, done, in_ready, out_valid, out_last} == 5'd0, "reset_ctrl", {busy, done, in_ready, out_valid, out_last}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      fill();
      run_frame(0, 2, 2, -1);
      img[0][0] = mk(1, 5, 2, 0);
      img[1][0] = mk(3, 2, 7, -1);
      run_frame(1, 1, 2, -1);
      img[2][0] = mk(9, 9, 9, 9);
      run_frame(2, 1, 3, -1);
      img[0][0] = mk(1, 2, 3, 4);
      run_frame(3, 1, 1, -1);
      img[0][0] = mk(-3, 4, -1, 0);
      run_frame(0, 1, 1, -1);
      run_frame(0, 0, 3, -1);
      run_frame(1, 2, 0, -1);
      rdy_pct = 40;
      fill();
      run_frame(1, 4, 5, -1);
      fill();
      run_frame(1, 3, 4, 7);
      fill();
      run_frame(1, 3, 4, -1);
      fill();
      run_frame(2, 2, 1, -1);
      for (int k = 0; k < 14; k++) begin
         rdy_pct = (k % 3 == 0) ? 100 : (k % 3 == 1) ? 60 : 25;
         fill();
         run_frame($urandom_range(3), $urandom_range(1, MRB), $urandom_range(1, 6), -1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
